// File: rtl/config_stream_loader_if.sv
// Byte-stream and fabric config-port bundle for config_stream_loader.
// The loader connects through the slave modport; the bitstream source and
// config observer use the master modport.
interface config_stream_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  start;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [WORD_WIDTH-1:0] SelfWriteData;
  logic                  SelfWriteStrobe;
  logic                  busy;
  logic                  done;
  logic [15:0]           word_count;

  modport master (
    output start, byte_data, byte_valid,
    input  byte_ready, SelfWriteData, SelfWriteStrobe, busy, done, word_count
  );

  modport slave (
    input  start, byte_data, byte_valid,
    output byte_ready, SelfWriteData, SelfWriteStrobe, busy, done, word_count
  );
endinterface

// File: rtl/config_stream_loader.sv
// config_stream_loader: packs a byte stream big-endian into WORD_WIDTH config
// words and writes each one to the fabric config port with a single-cycle
// strobe framed by SETUP_CYCLES of data setup and HOLD_CYCLES of data hold.
// A load ends after MAX_WORDS words.
// Optional feature macro: LOADER_SYNC_WORD_EN -- when defined, completed words
// are discarded after start until one matches the sync pattern 0xFAB0FAB1
// (low WORD_WIDTH bits for narrow words); that word and all later ones are
// written normally.
module config_stream_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2,
  parameter int MAX_WORDS    = 4096
) (
  input logic             CLK,
  input logic             resetn,
  config_stream_loader_if.slave bus
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int BCW   = $clog2(BYTES + 1);

  localparam logic [BCW-1:0] BYTE_LAST  = BCW'(BYTES - 1);
  localparam logic [3:0]     SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0]     HOLD_LAST  = 4'(HOLD_CYCLES - 1);
  localparam logic [15:0]    WORD_LAST  = 16'(MAX_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [BCW-1:0]        byte_cnt;
  logic [3:0]            cyc_cnt;
  logic [WORD_WIDTH-1:0] word_q;
  logic [WORD_WIDTH-1:0] word_nxt;
  logic [15:0]           word_count;

  logic start_go;
  logic xfer;
  logic last_byte;
  logic word_end;
  logic word_go;

  assign start_go  = bus.start && (state == IDLE || state == DONE);
  assign xfer      = bus.byte_valid && (state == COLLECT);
  assign last_byte = xfer && (byte_cnt == BYTE_LAST);
  assign word_end  = ((state == STROBE) && (HOLD_CYCLES == 0)) ||
                     ((state == HOLD) && (cyc_cnt == HOLD_LAST));

`ifdef LOADER_SYNC_WORD_EN
  localparam logic [31:0] SYNC32 = 32'hFAB0FAB1;

  logic synced;
  logic sync_hit;

  if (WORD_WIDTH >= 32) begin : g_sync_wide
    assign sync_hit = (word_nxt[31:0] == SYNC32);
  end else begin : g_sync_narrow
    assign sync_hit = (word_nxt == SYNC32[WORD_WIDTH-1:0]);
  end

  // Words before the first sync match are dropped without being written.
  assign word_go = synced || sync_hit;

  // Sync flag: cleared at every start, set by the first matching word.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      synced <= 1'b0;
    end else if (start_go) begin
      synced <= 1'b0;
    end else if (last_byte && sync_hit) begin
      synced <= 1'b1;
    end
  end
`else
  assign word_go = 1'b1;
`endif

  // Place the incoming byte into its big-endian lane of the word register.
  always_comb begin
    word_nxt = word_q;
    for (int i = 0; i < BYTES; i++) begin
      if (byte_cnt == BCW'(i)) begin
        word_nxt[WORD_WIDTH-1-8*i -: 8] = bus.byte_data;
      end
    end
  end

  // Next-state logic for the load sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (last_byte && word_go) state_nxt = (SETUP_CYCLES == 0) ? STROBE : SETUP;
      end
      SETUP: begin
        if (cyc_cnt == SETUP_LAST) state_nxt = STROBE;
      end
      STROBE: begin
        if (HOLD_CYCLES != 0) state_nxt = HOLD;
        else                  state_nxt = (word_count == WORD_LAST) ? DONE : COLLECT;
      end
      HOLD: begin
        if (cyc_cnt == HOLD_LAST) state_nxt = (word_count == WORD_LAST) ? DONE : COLLECT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Cycle counter times SETUP and HOLD; restarts on every state change.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      cyc_cnt <= '0;
    end else if ((state == SETUP || state == HOLD) && state_nxt == state) begin
      cyc_cnt <= cyc_cnt + 4'd1;
    end else begin
      cyc_cnt <= '0;
    end
  end

  // Byte lane counter: wraps at the end of each word, cleared on start.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      byte_cnt <= '0;
    end else if (start_go) begin
      byte_cnt <= '0;
    end else if (xfer) begin
      byte_cnt <= last_byte ? '0 : byte_cnt + BCW'(1);
    end
  end

  // Word register only moves on byte transfers, so it is stable through
  // SETUP, STROBE and HOLD.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)   word_q <= '0;
    else if (xfer) word_q <= word_nxt;
  end

  // Words written in the current load, counted as each HOLD completes.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)        word_count <= '0;
    else if (start_go)  word_count <= '0;
    else if (word_end)  word_count <= word_count + 16'd1;
  end

  assign bus.byte_ready      = (state == COLLECT);
  assign bus.busy            = (state == COLLECT) || (state == SETUP) ||
                               (state == STROBE)  || (state == HOLD);
  assign bus.SelfWriteStrobe = (state == STROBE);
  assign bus.done            = (state == DONE);
  assign bus.SelfWriteData   = word_q;
  assign bus.word_count      = word_count;

endmodule

// File: doc/config_stream_loader.md
CONFIG_STREAM_LOADER -- requirements
Module: config_stream_loader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, meaning the config word width in bits; it SHALL be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter SETUP_CYCLES, default 2, meaning the cycles SelfWriteData is stable before the strobe; range 0..15.
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, meaning the cycles SelfWriteData is held after the strobe; range 0..15.
REQ-004 SHALL have parameter MAX_WORDS, default 4096, meaning the number of words written per load; range 1..65535.
REQ-005 CLK  input  1  single clock; all logic is rising-edge.
REQ-006 resetn  input  1  reset, asynchronous and active-low.
REQ-007 start  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-008 byte_data  input  8  bitstream byte.
REQ-009 byte_valid  input  1  byte_data is valid.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 SelfWriteData  output  WORD_WIDTH  packed config word.
REQ-012 SelfWriteStrobe  output  1  one-cycle write pulse into the fabric config port.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  load complete; held until the next start.
REQ-015 word_count  output  16  words written in the current load.

Function
REQ-016 SHALL implement the states IDLE, COLLECT, SETUP, STROBE, HOLD and DONE; busy SHALL be high in COLLECT, SETUP, STROBE and HOLD only.
REQ-017 IDLE/DONE: start=1 SHALL move to COLLECT next cycle, clear word_count and clear done; start SHALL be ignored in every other state.
REQ-018 byte_ready SHALL equal 1 only in COLLECT; a byte SHALL transfer when byte_valid and byte_ready are both high in the same cycle.
REQ-019 Bytes SHALL pack big-endian: the first byte of a word SHALL go to SelfWriteData[WORD_WIDTH-1 -: 8]; SelfWriteData SHALL change only on byte transfers.
REQ-020 The transfer of byte WORD_WIDTH/8 SHALL move the state to SETUP next cycle; SETUP SHALL last SETUP_CYCLES cycles, or go straight to STROBE when SETUP_CYCLES is 0.
REQ-021 STROBE SHALL last exactly 1 cycle with SelfWriteStrobe=1; SelfWriteStrobe SHALL be 0 in every other state.
REQ-022 HOLD SHALL last HOLD_CYCLES cycles (skipped when 0); on leaving HOLD, word_count SHALL increment by 1.
REQ-023 After HOLD: if the incremented word_count equals MAX_WORDS, the state SHALL go to DONE with done=1; otherwise it SHALL return to COLLECT.
REQ-024 Gaps in byte_valid SHALL stall COLLECT indefinitely with no timeout; bytes SHALL never be dropped or duplicated.
REQ-025 Minimum per-word period: WORD_WIDTH/8 + SETUP_CYCLES + 1 + HOLD_CYCLES cycles.

Reset
REQ-026 resetn=0 SHALL immediately force IDLE, SelfWriteData=0, SelfWriteStrobe=0, byte_ready=0, busy=0, done=0, word_count=0 and clear the byte and cycle counters.
REQ-027 A reset during a load SHALL abandon the partial word; no strobe SHALL be issued after reset until a new start.

Configuration
REQ-028 Macro LOADER_SYNC_WORD_EN: when defined, after start the completed words SHALL be discarded (no SETUP/STROBE/HOLD, not counted) until a word equals the 32 LSBs 0xFAB0FAB1; that sync word and all later words SHALL be written normally. For WORD_WIDTH below 32, the match SHALL use the low WORD_WIDTH bits of 0xFAB0FAB1.
REQ-029 When LOADER_SYNC_WORD_EN is undefined, every word SHALL be written from the first byte, with no sync logic synthesised.

Verification
REQ-030 Defaults, start, bytes 12 34 56 78 streamed back-to-back -> SelfWriteData=0x12345678 with strobe 1 cycle, exactly 3 cycles after the 4th byte handshake; word_count=1.
REQ-031 MAX_WORDS=3, 12 bytes with random byte_valid gaps -> exactly 3 strobes, then done=1, busy=0, byte_ready=0 and word_count=3.
REQ-032 resetn pulsed low after 2 bytes of a word, then start and bytes AA BB CC DD -> the single strobe carries 0xAABBCCDD.
REQ-033 start asserted while busy -> ignored; word_count and state are unaffected.
REQ-034 With LOADER_SYNC_WORD_EN, words 0xFFFFFFFF, 0xFAB0FAB1, 0x00000001 -> 2 strobes (0xFAB0FAB1, 0x00000001) and word_count=2.
REQ-035 WORD_WIDTH=16, SETUP_CYCLES=0, HOLD_CYCLES=0 -> strobe is the cycle after the 2nd byte and byte_ready returns the following cycle.
